// File: rtl/mask_b_shift_unit_if.sv
// mask_b_shift_unit_if: request/response valid-ready bundle for the masked shifter
interface mask_b_shift_unit_if #(
  parameter int XLEN = 32,
  parameter int NS = 2
);
  localparam int SW = $clog2(XLEN);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [1:0] in_op;
  logic [SW-1:0] in_shamt;
  logic [NS*XLEN-1:0] in_rs;
  logic [NS*XLEN-1:0] in_prng;
  logic out_valid;
  logic out_ready;
  logic [NS*XLEN-1:0] out_rd;
  modport master (
    output flush, in_valid, in_op, in_shamt, in_rs, in_prng, out_ready,
    input in_ready, out_valid, out_rd
  );
  modport slave (
    input flush, in_valid, in_op, in_shamt, in_rs, in_prng, out_ready,
    output in_ready, out_valid, out_rd
  );
endinterface

// File: rtl/mask_b_shift_unit.sv
// mask_b_shift_unit: iterative SLL/SRL/SRA/ROR over NS Boolean shares; define MASK_B_SHIFT_REFRESH_EN to refresh shares on accept
module mask_b_shift_unit #(
  parameter int XLEN = 32,
  parameter int NS = 2
) (
  input logic g_clk,
  input logic g_resetn,
  mask_b_shift_unit_if.slave s
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] KEND = SW'(SW);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t st, nxt;
  logic rdy_q, vld_q, rdy_d, vld_d;
  logic [1:0] op;
  logic [SW-1:0] shamt, k, amt;
  logic [XLEN-1:0] sh [NS];
  logic [XLEN-1:0] ld [NS];
  logic acc, step;
  logic unused_prng;

  assign acc = st == IDLE && s.in_valid && !s.flush;
  assign amt = SW'(1) << k;
  assign step = |(shamt & amt);
  assign unused_prng = ^s.in_prng;

  function automatic logic [XLEN-1:0] shf(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [SW-1:0] n);
    logic [2*XLEN-1:0] w;
    w = {x, x} >> n;
    return o == 2'd0 ? x << n : o == 2'd1 ? x >> n : o == 2'd2 ? $unsigned($signed(x) >>> n) : w[XLEN-1:0];
  endfunction

`ifdef MASK_B_SHIFT_REFRESH_EN
  logic [XLEN-1:0] pacc;
  // shares 0..NS-2 take their own prng word; the last share absorbs the XOR of those words
  always_comb begin
    pacc = '0;
    for (int j = 0; j < NS - 1; j++) pacc = pacc ^ s.in_prng[j*XLEN +: XLEN];
    for (int j = 0; j < NS; j++) ld[j] = s.in_rs[j*XLEN +: XLEN] ^ (j == NS - 1 ? pacc : s.in_prng[j*XLEN +: XLEN]);
  end
`else
  // shares are captured unrefreshed
  always_comb begin
    for (int j = 0; j < NS; j++) ld[j] = s.in_rs[j*XLEN +: XLEN];
  end
`endif

  // state register plus registered handshake flags
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      st <= IDLE;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      st <= nxt;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
    end
  end

  // next state; flush overrides both handshakes, SHIFT ends once k has walked all SW stages
  always_comb begin
    nxt = s.flush ? IDLE :
          (st == IDLE && s.in_valid) ? SHIFT :
          (st == SHIFT && k == KEND) ? DONE :
          (st == DONE && s.out_ready) ? IDLE : st;
  end

  // handshake flags for the coming cycle follow the next state
  always_comb begin
    rdy_d = nxt == IDLE;
    vld_d = nxt == DONE;
  end

  // operand capture, then one conditional 2^k shift per share per SHIFT cycle
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      op <= '0;
      shamt <= '0;
      k <= '0;
      for (int j = 0; j < NS; j++) sh[j] <= '0;
    end else if (acc) begin
      op <= s.in_op;
      shamt <= s.in_shamt;
      k <= '0;
      for (int j = 0; j < NS; j++) sh[j] <= ld[j];
    end else if (st == SHIFT && k != KEND) begin
      k <= k + SW'(1);
      for (int j = 0; j < NS; j++) sh[j] <= step ? shf(op, sh[j], amt) : sh[j];
    end
  end

  assign s.in_ready = rdy_q;
  assign s.out_valid = vld_q;
  for (genvar i = 0; i < NS; i++) begin : g_out
    assign s.out_rd[i*XLEN +: XLEN] = sh[i];
  end
endmodule

// File: tb/tb_mask_b_shift_unit.sv
// tb_mask_b_shift_unit: directed and random checks of the masked shifter against a share-wise model
module tb_mask_b_shift_unit;
  localparam int XLEN = 32;
  localparam int NS = 2;
  localparam int LAT = 6;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [63:0] got;
  logic seen;

  mask_b_shift_unit_if #(.XLEN(XLEN), .NS(NS)) bus ();
  mask_b_shift_unit #(.XLEN(XLEN), .NS(NS)) dut (.g_clk(clk), .g_resetn(rstn), .s(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sh(input logic [1:0] op, input logic [31:0] x, input int n);
    logic [63:0] w;
    w = {x, x} >> n;
    case (op)
      2'd0: return x << n;
      2'd1: return x >> n;
      2'd2: return 32'($signed(x) >>> n);
      default: return w[31:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [4:0] n, input logic [63:0] rs);
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_shamt = n;
    bus.in_rs = rs;
    bus.in_prng = {$urandom, $urandom};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 40);
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [4:0] n,
                       input logic [31:0] s0, input logic [31:0] s1, output logic [63:0] r);
    int lat;
    start(op, n, {s1, s0});
    wait_valid(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    r = bus.out_rd;
    chk({tag, "_share0"}, {32'd0, r[31:0]}, {32'd0, ref_sh(op, s0, n)});
    chk({tag, "_share1"}, {32'd0, r[63:32]}, {32'd0, ref_sh(op, s1, n)});
    chk({tag, "_unmasked"}, {32'd0, r[31:0] ^ r[63:32]}, {32'd0, ref_sh(op, s0 ^ s1, n)});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ready_after"}, {63'd0, bus.in_ready}, 64'd1);
    chk({tag, "_valid_after"}, {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 2'd0;
    bus.in_shamt = '0;
    bus.in_rs = '0;
    bus.in_prng = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_out_rd", bus.out_rd, 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    do_op("sll4", 2'd0, 5'd4, 32'hA5A5A5A5, 32'hA5A5A5A4, got);
    chk("sll4_const0", {32'd0, got[31:0]}, 64'h5A5A5A50);
    chk("sll4_const1", {32'd0, got[63:32]}, 64'h5A5A5A40);
    chk("sll4_constx", {32'd0, got[31:0] ^ got[63:32]}, 64'h10);
    do_op("sra31", 2'd2, 5'd31, 32'h12345678, 32'h92345678, got);
    chk("sra31_constx", {32'd0, got[31:0] ^ got[63:32]}, 64'hFFFFFFFF);
    do_op("srl31", 2'd1, 5'd31, 32'h12345678, 32'h92345678, got);
    chk("srl31_constx", {32'd0, got[31:0] ^ got[63:32]}, 64'h1);
    do_op("ror1", 2'd3, 5'd1, 32'hDEADBEEF, 32'hDEADBEEE, got);
    chk("ror1_constx", {32'd0, got[31:0] ^ got[63:32]}, 64'h80000000);
    for (int o = 0; o < 4; o++) begin
      do_op("shamt0", 2'(o), 5'd0, 32'h0BADF00D, 32'hC0FFEE11, got);
      chk("shamt0_identity", got, 64'hC0FFEE11_0BADF00D);
    end

    start(2'd2, 5'd7, 64'h8765_4321_F00D_CAFE);
    begin
      int lat;
      wait_valid(lat);
      chk("bp_latency", 64'(lat), 64'(LAT));
    end
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_rd", bus.out_rd, {ref_sh(2'd2, 32'h87654321, 7), ref_sh(2'd2, 32'hF00DCAFE, 7)});
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);

    start(2'd0, 5'd3, 64'h1111_2222_3333_4444);
    repeat (2) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      seen = seen | bus.out_valid;
      @(posedge clk);
      #1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);
    do_op("post_flush", 2'd3, 5'd13, 32'h0F1E2D3C, 32'h4B5A6978, got);

    start(2'd1, 5'd9, 64'hFFFF_0000_AAAA_5555);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midreset_out_rd", bus.out_rd, 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    do_op("post_reset", 2'd2, 5'd17, 32'hF3C3A5A5, 32'h1234FEDC, got);

    for (int t = 0; t < 24; t++) begin
      do_op("random", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom, got);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
